muldiv_iter: RTL and testbench

Parametrised iterative multiply/divide unit for the execute stage: replaces the fixed 32-bit start/done multiplier and divider pair with one shared engine. It has a valid/ready operand handshake, a valid/ready result handshake, a result tag, and pipeline flush. It computes all RISC-style MUL/MULH/MULHU/DIV/DIVU/REM/REMU results on XLEN-bit operands, with architecturally defined divide-by-zero and overflow results.

---
 rtl/muldiv_iter.sv | 125 ++++++++++++
 tb/tb_muldiv_iter.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/muldiv_iter.sv
// muldiv_iter: shared iterative MUL/MULH/MULHU/DIV/DIVU/REM/REMU engine with valid/ready, tag and flush.
// Define MULDIV_FAST_MUL_EN to collapse multiply CALC to a single cycle.
module muldiv_iter #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5
) (
  input  logic             cpu_clk,
  input  logic             cpu_rstn,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_op,
  input  logic [XLEN-1:0]  in_a,
  input  logic [XLEN-1:0]  in_b,
  input  logic [TAG_W-1:0] in_tag,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_result,
  output logic [TAG_W-1:0] out_tag,
  output logic             busy
);
  localparam int CW = $clog2(XLEN);
`ifdef MULDIV_FAST_MUL_EN
  localparam int MUL_N = 1;
`else
  localparam int MUL_N = XLEN;
`endif
  localparam logic [XLEN-1:0] MIN = {1'b1, {(XLEN-1){1'b0}}};
  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;
  state_t state;
  logic [2:0] op;
  logic [CW-1:0] cnt;
  logic [XLEN-1:0] b;
  logic [2*XLEN-1:0] acc;
  logic neg_q, neg_r;
  logic [2:0] in_opc;
  logic in_mul, in_sgn, a_neg, b_neg, div0, ovf, special;
  logic [XLEN-1:0] a_mag, b_mag;
  logic [2*XLEN-1:0] spec_acc;
  assign in_opc   = (in_op == 3'd7) ? 3'd0 : in_op;
  assign in_mul   = in_opc < 3'd3;
  assign in_sgn   = (in_opc == 3'd1) | (in_opc == 3'd3) | (in_opc == 3'd5);
  assign a_neg    = in_sgn & in_a[XLEN-1];
  assign b_neg    = in_sgn & in_b[XLEN-1];
  assign a_mag    = a_neg ? -in_a : in_a;
  assign b_mag    = b_neg ? -in_b : in_b;
  assign div0     = !in_mul & (in_b == '0);
  assign ovf      = ((in_opc == 3'd3) | (in_opc == 3'd5)) & (in_a == MIN) & (in_b == '1);
  assign special  = div0 | ovf;
  // acc holds {remainder, quotient}; divide-by-zero yields {a, all-ones}
  assign spec_acc = div0 ? {in_a, {XLEN{1'b1}}} : {{XLEN{1'b0}}, MIN};
  logic mul;
  logic [XLEN:0] msum, t;
  logic ge;
  logic [XLEN-1:0] td;
  logic [2*XLEN-1:0] mul_next, div_next;
  assign mul  = op < 3'd3;
  assign msum = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, b} : {(XLEN+1){1'b0}});
  assign t    = acc[2*XLEN-1:XLEN-1];
  assign ge   = t >= {1'b0, b};
  assign td   = ge ? t[XLEN-1:0] - b : t[XLEN-1:0];
`ifdef MULDIV_FAST_MUL_EN
  logic signed [XLEN:0] fa, fb;
  logic signed [2*XLEN-1:0] fprod;
  assign fa       = $signed({1'b0, acc[XLEN-1:0]});
  assign fb       = $signed({1'b0, b});
  assign fprod    = fa * fb;
  assign mul_next = fprod;
`else
  assign mul_next = {msum, acc[XLEN-1:1]};
`endif
  assign div_next = {td, acc[XLEN-2:0], ge};
  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0] q, r, res;
  assign prod = neg_q ? -acc : acc;
  assign q    = neg_q ? -acc[XLEN-1:0] : acc[XLEN-1:0];
  assign r    = neg_r ? -acc[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN];
  assign res  = (op == 3'd0) ? prod[XLEN-1:0] : (op < 3'd3) ? prod[2*XLEN-1:XLEN] : (op < 3'd5) ? q : r;
  assign in_ready = (state == IDLE) & !flush;
  assign busy     = state != IDLE;
  always_ff @(posedge cpu_clk or negedge cpu_rstn) begin
    if (!cpu_rstn) begin
      state      <= IDLE;
      out_valid  <= 1'b0;
      out_result <= '0;
      out_tag    <= '0;
      cnt        <= '0;
      op         <= '0;
      b          <= '0;
      acc        <= '0;
      neg_q      <= 1'b0;
      neg_r      <= 1'b0;
    end else if (flush) begin
      state     <= IDLE;
      out_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          op      <= in_opc;
          out_tag <= in_tag;
          b       <= b_mag;
          acc     <= special ? spec_acc : {{XLEN{1'b0}}, a_mag};
          neg_q   <= !special & (a_neg ^ b_neg);
          neg_r   <= !special & a_neg;
          cnt     <= in_mul ? CW'(MUL_N - 1) : CW'(XLEN - 1);
          state   <= special ? FIX : CALC;
        end
        CALC: begin
          acc <= mul ? mul_next : div_next;
          cnt <= cnt - 1'b1;
          if (cnt == '0) state <= FIX;
        end
        FIX: begin
          out_result <= res;
          out_valid  <= 1'b1;
          state      <= DONE;
        end
        default: if (out_ready) begin
          out_valid <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_muldiv_iter.sv
// tb_muldiv_iter: directed and random checks of muldiv_iter against an arithmetic reference model.
module tb_muldiv_iter;
  localparam int XLEN = 32;
  localparam int TAG_W = 5;
`ifdef MULDIV_FAST_MUL_EN
  localparam int MLAT = 2;
`else
  localparam int MLAT = XLEN + 1;
`endif
  localparam logic [31:0] MIN = 32'h8000_0000;
  logic cpu_clk, cpu_rstn, in_valid, in_ready, flush, out_valid, out_ready, busy;
  logic [2:0] in_op;
  logic [XLEN-1:0] in_a, in_b, out_result;
  logic [TAG_W-1:0] in_tag, out_tag;
  int checks = 0, errors = 0;
  logic exp_idle, exp_valid;
  logic [31:0] exp_result;
  logic [TAG_W-1:0] exp_tag;

  muldiv_iter #(.XLEN(XLEN), .TAG_W(TAG_W)) dut (
    .cpu_clk(cpu_clk), .cpu_rstn(cpu_rstn), .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_a(in_a), .in_b(in_b), .in_tag(in_tag), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_tag(out_tag), .busy(busy)
  );

  initial cpu_clk = 1'b0;
  always #5 cpu_clk = ~cpu_clk;

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h at %0t", nm, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, p;
    longint unsigned ua, ub, pu;
    logic ov;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    ov = (a == MIN) && (b == 32'hFFFF_FFFF);
    case (op)
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin pu = ua * ub; return pu[63:32]; end
      3'd3: begin p = sa / sb; return (b == 0) ? 32'hFFFF_FFFF : ov ? MIN : p[31:0]; end
      3'd4: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd5: begin p = sa % sb; return (b == 0) ? a : ov ? 32'd0 : p[31:0]; end
      3'd6: return (b == 0) ? a : a % b;
      default: return a * b;
    endcase
  endfunction

  function automatic int latency(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    if (op < 3'd3 || op == 3'd7) return MLAT;
    if (b == 0) return 1;
    if ((op == 3'd3 || op == 3'd5) && a == MIN && b == 32'hFFFF_FFFF) return 1;
    return XLEN + 1;
  endfunction

  // Every cycle: handshake outputs follow the model's expected state; results checked while valid.
  always @(negedge cpu_clk) begin
    if (cpu_rstn) begin
      chk("out_valid", out_valid, exp_valid);
      chk("in_ready", in_ready, exp_idle & !flush);
      chk("busy", busy, !exp_idle);
      if (exp_valid) begin
        chk("out_result", out_result, exp_result);
        chk("out_tag", out_tag, exp_tag);
      end
    end
  end

  task automatic do_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [TAG_W-1:0] tag, input int hold, input bit has_lit, input logic [31:0] lit);
    if (has_lit) chk("model_pin", model(op, a, b), lit);
    in_valid = 1'b1; in_op = op; in_a = a; in_b = b; in_tag = tag;
    exp_result = model(op, a, b);
    exp_tag = tag;
    @(posedge cpu_clk); #1;
    in_valid = 1'b0; in_a = $urandom; in_b = $urandom; in_tag = TAG_W'($urandom); in_op = 3'($urandom);
    exp_idle = 1'b0;
    repeat (latency(op, a, b)) @(posedge cpu_clk);
    #1;
    exp_valid = 1'b1;
    repeat (hold) begin @(posedge cpu_clk); #1; end
    out_ready = 1'b1;
    @(posedge cpu_clk); #1;
    out_ready = 1'b0;
    exp_valid = 1'b0;
    exp_idle = 1'b1;
  endtask

  task automatic abort_test(input bit use_reset);
    in_valid = 1'b1; in_op = 3'd4; in_a = 32'h1234_5678; in_b = 32'd13; in_tag = 5'd21;
    @(posedge cpu_clk); #1;
    in_valid = 1'b0;
    exp_idle = 1'b0;
    repeat (10) @(posedge cpu_clk);
    #1;
    if (use_reset) begin
      cpu_rstn = 1'b0;
      #1;
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_result", out_result, 0);
      chk("rst_out_tag", out_tag, 0);
      chk("rst_busy", busy, 0);
      @(posedge cpu_clk); #1;
      cpu_rstn = 1'b1;
    end else begin
      flush = 1'b1; in_valid = 1'b1; in_op = 3'd0; in_a = 32'd3; in_b = 32'd5; in_tag = 5'd9;
      @(posedge cpu_clk); #1;
      flush = 1'b0; in_valid = 1'b0;
    end
    exp_idle = 1'b1;
    repeat (40) @(posedge cpu_clk);
    #1;
    do_op(3'd3, 32'hFFFF_FF9C, 32'd7, 5'd17, 0, 1, 32'hFFFF_FFF2);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 9))
      0: return 32'd0;
      1: return 32'hFFFF_FFFF;
      2: return MIN;
      3: return 32'($urandom_range(1, 20));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    cpu_rstn = 1'b0; in_valid = 1'b0; in_op = '0; in_a = '0; in_b = '0; in_tag = '0;
    flush = 1'b0; out_ready = 1'b0;
    exp_idle = 1'b1; exp_valid = 1'b0; exp_result = '0; exp_tag = '0;
    #12;
    chk("reset_out_valid", out_valid, 0);
    chk("reset_out_result", out_result, 0);
    chk("reset_out_tag", out_tag, 0);
    chk("reset_busy", busy, 0);
    @(posedge cpu_clk); #1;
    cpu_rstn = 1'b1;
    @(posedge cpu_clk); #1;
    do_op(3'd0, 32'hFFFF_FFFF, 32'd7, 5'd3, 0, 1, 32'hFFFF_FFF9);
    do_op(3'd1, MIN, MIN, 5'd1, 0, 1, 32'h4000_0000);
    do_op(3'd2, MIN, MIN, 5'd2, 1, 1, 32'h4000_0000);
    do_op(3'd1, MIN, 32'd1, 5'd4, 0, 1, 32'hFFFF_FFFF);
    do_op(3'd3, 32'hFFFF_FFF9, 32'd2, 5'd5, 0, 1, 32'hFFFF_FFFD);
    do_op(3'd5, 32'hFFFF_FFF9, 32'd2, 5'd6, 0, 1, 32'hFFFF_FFFF);
    do_op(3'd4, 32'd100, 32'd7, 5'd7, 0, 1, 32'd14);
    do_op(3'd6, 32'd100, 32'd7, 5'd8, 0, 1, 32'd2);
    do_op(3'd4, 32'd5, 32'd0, 5'd10, 0, 1, 32'hFFFF_FFFF);
    do_op(3'd5, 32'd5, 32'd0, 5'd11, 0, 1, 32'd5);
    do_op(3'd3, MIN, 32'hFFFF_FFFF, 5'd12, 0, 1, MIN);
    do_op(3'd5, MIN, 32'hFFFF_FFFF, 5'd13, 0, 1, 32'd0);
    do_op(3'd7, 32'd6, 32'd9, 5'd14, 0, 1, 32'd54);
    do_op(3'd6, 32'd77, 32'd10, 5'd15, 10, 1, 32'd7);
    do_op(3'd0, 32'd12, 32'd12, 5'd16, 0, 1, 32'd144);
    abort_test(1'b0);
    abort_test(1'b1);
    for (int i = 0; i < 150; i++)
      do_op(3'($urandom), pick(), pick(), TAG_W'($urandom), $urandom_range(0, 3), 0, 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
